matrixify_core: RTL and testbench



---
 rtl/matrixify_core.sv | 74 +++++++
 tb/tb_matrixify_core.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrixify_core.sv
// ============================================================================
// matrixify_core: registers a 128-bit block as a 4x4 column-major byte matrix;
// MATRIXIFY_INVERSE_EN adds the matrix-to-block inverse path.  Rev 1.0
// ============================================================================
`default_nettype none

module matrixify_core (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [127:0]          rawstring,
  output logic                  out_valid,
  output logic [3:0][3:0][7:0]  matrix
`ifdef MATRIXIFY_INVERSE_EN
  ,
  input  logic [3:0][3:0][7:0]  mat_in,
  input  logic                  mat_in_valid,
  output logic [127:0]          rawstring_out,
  output logic                  rawstring_out_valid
`endif
);

  logic [3:0][3:0][7:0] mapped;

  // Byte 4*c+r of the block lands in row r, column c.
  always_comb begin
    mapped = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        mapped[r][c] = rawstring[8*(4*c+r) +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      matrix    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        matrix <= mapped;
      end
    end
  end

`ifdef MATRIXIFY_INVERSE_EN
  logic [127:0] unmapped;

  always_comb begin
    unmapped = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        unmapped[8*(4*c+r) +: 8] = mat_in[r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rawstring_out       <= '0;
      rawstring_out_valid <= 1'b0;
    end else begin
      rawstring_out_valid <= mat_in_valid;
      if (mat_in_valid) begin
        rawstring_out <= unmapped;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_matrixify_core.sv
// ============================================================================
// tb_matrixify_core: directed + random self-checking bench for matrixify_core.
// ============================================================================
`default_nettype none

module tb_matrixify_core;

  typedef logic [3:0][3:0][7:0] mat_t;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [127:0]  rawstring;
  logic          out_valid;
  mat_t          matrix;
`ifdef MATRIXIFY_INVERSE_EN
  mat_t          mat_in;
  logic          mat_in_valid;
  logic [127:0]  rawstring_out;
  logic          rawstring_out_valid;
  logic [127:0]  exp_raw_out;
  logic          exp_raw_out_valid;
`endif

  int checks;
  int failures;

  mat_t exp_matrix;
  logic exp_valid;

  matrixify_core dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .rawstring (rawstring),
    .out_valid (out_valid),
    .matrix    (matrix)
`ifdef MATRIXIFY_INVERSE_EN
    ,
    .mat_in              (mat_in),
    .mat_in_valid        (mat_in_valid),
    .rawstring_out       (rawstring_out),
    .rawstring_out_valid (rawstring_out_valid)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: walk the 16 block bytes in order; byte k sits at row k%4, col k/4.
  function automatic mat_t ref_map(input logic [127:0] raw);
    mat_t m;
    m = '0;
    for (int k = 0; k < 16; k++) m[k % 4][k / 4] = raw[8*k +: 8];
    return m;
  endfunction

  function automatic logic [127:0] ref_unmap(input mat_t m);
    logic [127:0] raw;
    raw = '0;
    for (int k = 0; k < 16; k++) raw[8*k +: 8] = m[k % 4][k / 4];
    return raw;
  endfunction

  task automatic check_outputs(input string tag);
    checks++;
    assert (out_valid === exp_valid) else begin
      failures++;
      $error("FAIL %s out_valid observed=%b expected=%b", tag, out_valid, exp_valid);
    end
    checks++;
    assert (matrix === exp_matrix) else begin
      failures++;
      $error("FAIL %s matrix observed=%h expected=%h", tag, matrix, exp_matrix);
    end
`ifdef MATRIXIFY_INVERSE_EN
    checks++;
    assert (rawstring_out_valid === exp_raw_out_valid && rawstring_out === exp_raw_out) else begin
      failures++;
      $error("FAIL %s inverse observed=%b/%h expected=%b/%h", tag, rawstring_out_valid,
             rawstring_out, exp_raw_out_valid, exp_raw_out);
    end
`endif
  endtask

  // Apply one cycle of stimulus, advance the reference model, then compare.
  task automatic cycle(input logic rst, input logic vld, input logic [127:0] raw, input string tag);
    reset     = rst;
    in_valid  = vld;
    rawstring = raw;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_matrix = '0;
      exp_valid  = 1'b0;
    end else begin
      exp_valid = vld;
      if (vld) exp_matrix = ref_map(raw);
    end
`ifdef MATRIXIFY_INVERSE_EN
    if (rst) begin
      exp_raw_out       = '0;
      exp_raw_out_valid = 1'b0;
    end else begin
      exp_raw_out_valid = mat_in_valid;
      if (mat_in_valid) exp_raw_out = ref_unmap(mat_in);
    end
`endif
    check_outputs(tag);
  endtask

  task automatic check_byte(input int r, input int c, input logic [7:0] val);
    checks++;
    assert (matrix[r][c] === val) else begin
      failures++;
      $error("FAIL known_vector[%0d][%0d] observed=%h expected=%h", r, c, matrix[r][c], val);
    end
  endtask

  logic [127:0] rnd;
  logic [127:0] orig;

  initial begin
    checks     = 0;
    failures   = 0;
    exp_matrix = '0;
    exp_valid  = 1'b0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    rawstring  = '0;
`ifdef MATRIXIFY_INVERSE_EN
    mat_in            = '0;
    mat_in_valid      = 1'b0;
    exp_raw_out       = '0;
    exp_raw_out_valid = 1'b0;
`endif

    cycle(1'b1, 1'b0, '0, "reset_a");
    cycle(1'b1, 1'b0, '0, "reset_b");

    // Known vector, accepted on the first edge after reset release.
    cycle(1'b0, 1'b1, 128'h121b1904_637a1279_74620d15_77056458, "known_vector");
    check_byte(3, 3, 8'h12);
    check_byte(2, 2, 8'h7a);
    check_byte(2, 0, 8'h05);
    check_byte(1, 3, 8'h19);
    check_byte(1, 1, 8'h0d);
    check_byte(0, 0, 8'h58);
    check_byte(3, 0, 8'h77);
    check_byte(0, 3, 8'h04);
    check_byte(1, 0, 8'h64);

    // Reset wins over a simultaneous load.
    cycle(1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, "preload");
    cycle(1'b1, 1'b1, {128{1'b1}}, "reset_priority");

    // Back-to-back loads.
    cycle(1'b0, 1'b1, 128'h000102030405060708090a0b0c0d0e0f, "b2b_first");
    check_byte(0, 0, 8'h0f);
    cycle(1'b0, 1'b1, 128'h0f0e0d0c0b0a09080706050403020100, "b2b_second");
    check_byte(0, 0, 8'h00);

    // Hold while in_valid is low and rawstring churns.
    cycle(1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, "hold_load");
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, {$urandom, $urandom, $urandom, $urandom}, "hold");
    end

    // Walking one: exactly one bit set, at the reference position.
    for (int b = 0; b < 128; b++) begin
      rnd = '0;
      rnd[b] = 1'b1;
      cycle(1'b0, 1'b1, rnd, "walking_one");
      checks++;
      assert ($countones(matrix) === 1) else begin
        failures++;
        $error("FAIL walking_one_count bit=%0d observed=%0d expected=1", b, $countones(matrix));
      end
    end

    // Random traffic with sparse resets.
    for (int i = 0; i < 60; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      cycle(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, rnd, "random");
    end

`ifdef MATRIXIFY_INVERSE_EN
    // Round trip: forward output fed back through the inverse path.
    orig = {$urandom, $urandom, $urandom, $urandom};
    cycle(1'b0, 1'b1, orig, "roundtrip_fwd");
    mat_in       = matrix;
    mat_in_valid = 1'b1;
    cycle(1'b0, 1'b0, {$urandom, $urandom, $urandom, $urandom}, "roundtrip_inv");
    mat_in_valid = 1'b0;
    checks++;
    assert (rawstring_out === orig && rawstring_out_valid === 1'b1) else begin
      failures++;
      $error("FAIL roundtrip observed=%h expected=%h", rawstring_out, orig);
    end
    for (int i = 0; i < 20; i++) begin
      mat_in       = mat_t'({$urandom, $urandom, $urandom, $urandom});
      mat_in_valid = ($urandom_range(0, 1) == 1);
      cycle(1'b0, $urandom_range(0, 1) == 1, {$urandom, $urandom, $urandom, $urandom}, "inv_random");
    end
    mat_in_valid = 1'b0;
`else
    orig = '0;
`endif

    cycle(1'b0, 1'b0, orig, "final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
